// File: rtl/ddr_capture_deser.sv
// Dual-edge serial capture into WIDTH-bit words, LSB first,
// buffered by a first-word-fall-through FIFO with valid/ready.
module ddr_capture_deser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       data,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int HALF = WIDTH / 2;
  localparam int PCW  = $clog2(HALF + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);

  logic             pos_bit;
  logic             neg_bit;
  logic             pair_pend;
  logic [PCW-1:0]   pair_cnt;
  logic [PCW-1:0]   cnt_inc;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic             word_done;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  always_comb begin
    sr_shift           = sr >> 2;
    sr_shift[WIDTH-1]  = neg_bit;
    sr_shift[WIDTH-2]  = pos_bit;
    cnt_inc            = pair_cnt + PCW'(1);
    word_done          = pair_pend && (cnt_inc == PCW'(HALF));
  end

  assign full    = (count == CW'(DEPTH));
  assign q_valid = (count != '0);
  assign pop     = q_valid & q_ready;
  assign push    = word_done & (~full | pop);
  assign drop    = word_done & full & ~pop;
  assign q       = mem[rd_ptr];

  // Rising-edge path: first bit of each pair and pair absorption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_bit   <= 1'b0;
      pair_pend <= 1'b0;
      pair_cnt  <= '0;
      sr        <= '0;
    end else begin
      pair_pend <= en;
      if (en) pos_bit <= data;
      if (pair_pend) begin
        sr       <= sr_shift;
        pair_cnt <= word_done ? '0 : cnt_inc;
      end
    end
  end

  // Falling-edge path: second bit of a pending pair.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      neg_bit <= 1'b0;
    end else if (pair_pend) begin
      neg_bit <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sr_shift;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/ddr_capture_deser.md
# ddr_capture_deser

Dual-edge serial capture stage that feeds the edge-sensitive `q` output path. It samples a 1-bit `data` line on both the rising and falling edge of `clk` and assembles the bits, LSB first, into `WIDTH`-bit words. Completed words go into a small first-word-fall-through FIFO with a valid/ready handshake toward the downstream consumer. Rising-edge and falling-edge samples are handled as separate capture paths, matching the posedge/negedge path split of the downstream timing model.

## Interface
- `WIDTH`, default 8: output word width; even, ≥ 2.
- `DEPTH`, default 4: FIFO depth in words; power of two, ≥ 2.
- `clk`  input  1  single clock; both edges are used for sampling.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  capture enable, sampled on posedge.
- `data`  input  1  serial data, sampled on posedge and on negedge.
- `q`  output  WIDTH  FIFO head word; bit 0 is the earliest-received bit.
- `q_valid`  output  1  FIFO non-empty.
- `q_ready`  input  1  consumer accepts the head word when `q_valid & q_ready` at posedge.
- `count`  output  $clog2(DEPTH+1)  number of words in the FIFO.
- `overflow`  output  1  sticky; a completed word was dropped.

## Operation
- **Pair capture**
  - At posedge with `en`=1: `pos_bit`←`data`, and `pair_pend` is set.
  - At the following negedge: `neg_bit`←`data`. `neg_bit` is the only negedge flop; all other state is posedge.
  - At the next posedge with `pair_pend`=1: the pair is absorbed, `sr`←{`neg_bit`,`pos_bit`,`sr[WIDTH-1:2]`}, and `pair_cnt` increments.
  - `pair_pend` follows `en` each posedge, so back-to-back pairs stream continuously.
- **Word complete**
  - When the absorbed pair makes `pair_cnt` reach `WIDTH/2`, the shifted value is written to the FIFO on that same edge.
  - `pair_cnt` then wraps to 0. No extra cycle is inserted between words.
- **`en` low**
  - No new pair starts. `sr` and `pair_cnt` hold, so a partial word is retained and resumes when `en` returns.
  - A pending pair is still absorbed on the next posedge.
- **FIFO**
  - Circular buffer with `log2(DEPTH)`-bit pointers plus `count`.
  - `q` = `mem[rd_ptr]`, first-word fall-through.
  - Pop when `q_valid & q_ready`.
- **Full**
  - Write with no pop on the same edge: the word is dropped, `overflow` is set (cleared only by `rst`), and `count` stays at `DEPTH`.
  - Write and pop on the same edge while full: both occur and `count` is unchanged.
- **Empty**
  - `q_valid`=0 and `q_ready` is ignored.
  - Write and pop on the same edge while empty: only the write occurs, because there is no valid head to pop.
- **Pointer wrap:** modulo `DEPTH`.
- **Reset** (asynchronous, any time including mid-word)
  - Clears `sr`, `pos_bit`, `neg_bit`, `pair_pend`, `pair_cnt`, pointers, `count` and `overflow`.
  - A partial word is discarded.
- **Output reset values:** `q`=0 (memory cleared), `q_valid`=0, `count`=0, `overflow`=0.

## Timing
- **Capture and write:** with `en` high from posedge 0, bits are sampled at posedges 0..WIDTH/2−1 and at the negedges between them. Pairs are absorbed at posedges 1..WIDTH/2. The word is written at posedge WIDTH/2, and `q_valid`=1 is visible after that edge. For `WIDTH`=8, the write is at posedge 4.
- **Throughput:** one word per WIDTH/2 clocks.
- **Pop:** takes effect at the posedge; the next head word or `q_valid`=0 appears after that same edge.
- **Status outputs:** `count`, `overflow` and `q_valid` are registered and change only on posedge or `rst`.
- **Reset release:** the first sample after `rst` falls is the first posedge with `en`=1.

## Test plan
- **Single word:** `WIDTH`=8, `en`=1. Bits in order (pos,neg,…) are 1,0,1,1,0,0,1,0. Required: `q`=8'h4D, with `q_valid` rising after posedge 4 and `count`=1.
- **Fill and overflow:** `q_ready`=0 and 5 words streamed with `DEPTH`=4. Required: `count` saturates at 4 and `overflow`=1 after the 5th word's edge. Draining with `q_ready`=1 then returns words 1–4 in order, and `overflow` stays 1.
- **Full with simultaneous pop:** FIFO full, `q_ready`=1 on the same edge a word completes. Required: no overflow, `count` stays 4, and the new word appears last in the drain order.
- **Gap in `en`:** `en` drops for 3 cycles after 2 pairs, then resumes. Required: the assembled word equals the ungapped result and the completion edge is delayed by exactly 3 cycles.
- **Reset mid-word:** `rst` pulses after 3 pairs while the FIFO holds 2 words. Required: all outputs read 0 immediately. A following full 4-pair word yields exactly 1 word, whose value is built only from the post-reset bits.
- **Streaming:** continuous `en` and `q_ready`=1 for 16 words of alternating 8'hA5/8'h3C. Required: every word is received in order with no drops, and `count` never exceeds 1.
